// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: tracks the remaining producer latency of every
// in-flight integer and FP destination and stalls ID on RAW, WAW or a busy divider.
module hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int FP_LAT   = 2,
    parameter int FDIV_LAT = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  stall_cause,
    output logic        fdiv_busy
);

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_STOREFP = 7'b0100111;
    localparam logic [6:0] OPC_OP_FP   = 7'b1010011;

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] LAT_FP   = CNT_W'(FP_LAT);
    localparam logic [CNT_W-1:0] LAT_DIV  = CNT_W'(FDIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] xcnt_q [32];
    logic [CNT_W-1:0] xcnt_d [32];
    logic [CNT_W-1:0] fcnt_q [32];
    logic [CNT_W-1:0] fcnt_d [32];
    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    logic [6:0] opcode;
    logic [4:0] funct5;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       unused_bits;

    assign opcode      = id_instr[6:0];
    assign funct5      = id_instr[31:27];
    assign rd          = id_instr[11:7];
    assign rs1         = id_instr[19:15];
    assign rs2         = id_instr[24:20];
    assign unused_bits = ^{id_instr[26:25], id_instr[14:12]};

    logic             rd_x;
    logic             rd_f;
    logic [CNT_W-1:0] lat;
    logic             uses_div;
    logic             use_xrs1;
    logic             use_xrs2;
    logic             use_frs1;
    logic             use_frs2;

    // Decode destination file, producer latency and which source operands are read.
    always_comb begin
        rd_x     = 1'b0;
        rd_f     = 1'b0;
        lat      = '0;
        uses_div = 1'b0;
        use_xrs1 = 1'b1;
        use_xrs2 = 1'b0;
        use_frs1 = 1'b0;
        use_frs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                rd_x     = 1'b1;
                use_xrs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_JALR: rd_x = 1'b1;
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rd_x     = 1'b1;
                use_xrs1 = 1'b0;
            end
            OPC_LOAD: begin
                rd_x = 1'b1;
                lat  = LAT_LOAD;
            end
            OPC_LOAD_FP: begin
                rd_f = 1'b1;
                lat  = LAT_LOAD;
            end
            OPC_STORE, OPC_BRANCH: use_xrs2 = 1'b1;
            OPC_STOREFP: use_frs2 = 1'b1;
            OPC_OP_FP: begin
                // Moves/converts from the integer file read rs1 from x, everything else from f.
                use_xrs1 = (funct5 == 5'b11010) || (funct5 == 5'b11110);
                use_frs1 = !((funct5 == 5'b11010) || (funct5 == 5'b11110));
                use_frs2 = !(funct5 inside {5'b01011, 5'b11000, 5'b11010, 5'b11100, 5'b11110});
                if (funct5 == 5'b00011 || funct5 == 5'b01011) begin
                    rd_f     = 1'b1;
                    lat      = LAT_DIV;
                    uses_div = 1'b1;
                end else if (funct5 inside {5'b10100, 5'b11000, 5'b11100}) begin
                    rd_x = 1'b1;
                    lat  = LAT_FP;
                end else begin
                    rd_f = 1'b1;
                    lat  = LAT_FP;
                end
            end
            default: ;
        endcase
    end

    logic             raw;
    logic             strct;
    logic             waw;
    logic             issue;
    logic [CNT_W-1:0] rd_cnt;
    logic             rd_tracked;

    // Hazard detection; x0 is never a real source or destination.
    always_comb begin
        raw = id_valid && (
              (use_xrs1 && rs1 != 5'd0 && xcnt_q[rs1] != '0) ||
              (use_xrs2 && rs2 != 5'd0 && xcnt_q[rs2] != '0) ||
              (use_frs1 && fcnt_q[rs1] != '0) ||
              (use_frs2 && fcnt_q[rs2] != '0));
        strct      = id_valid && uses_div && (div_cnt_q != '0);
        rd_tracked = (rd_x && rd != 5'd0) || rd_f;
        rd_cnt     = rd_x ? xcnt_q[rd] : (rd_f ? fcnt_q[rd] : '0);
        waw        = id_valid && rd_tracked && (rd_cnt > lat);
        stall      = raw || strct || waw;
        if (raw)        stall_cause = 2'b01;
        else if (strct) stall_cause = 2'b10;
        else if (waw)   stall_cause = 2'b11;
        else            stall_cause = 2'b00;
        issue      = id_valid && !stall && !flush;
        fdiv_busy  = (div_cnt_q != '0);
    end

    // Counters count down to zero; an issuing producer reloads its destination counter.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            xcnt_d[i] = (xcnt_q[i] != '0) ? xcnt_q[i] - CNT_ONE : '0;
            fcnt_d[i] = (fcnt_q[i] != '0) ? fcnt_q[i] - CNT_ONE : '0;
            if (issue && rd_x && lat != '0 && rd == 5'(i)) xcnt_d[i] = lat;
            if (issue && rd_f && lat != '0 && rd == 5'(i)) fcnt_d[i] = lat;
        end
        xcnt_d[0] = '0;
        div_cnt_d = (div_cnt_q != '0) ? div_cnt_q - CNT_ONE : '0;
        if (issue && uses_div) div_cnt_d = LAT_DIV;
    end

    // Counter state with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                xcnt_q[i] <= '0;
                fcnt_q[i] <= '0;
            end
            div_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                xcnt_q[i] <= xcnt_d[i];
                fcnt_q[i] <= fcnt_d[i];
            end
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: table of single-cycle vectors followed by
// hand-written divider and reset sequences; expectations go through a queue.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic [1:0]  stall_cause;
    logic        fdiv_busy;

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .flush       (flush),
        .stall       (stall),
        .stall_cause (stall_cause),
        .fdiv_busy   (fdiv_busy)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] FLW   = 7'b0000111;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] OPFP  = 7'b1010011;

    function automatic logic [31:0] enc_r(input logic [4:0] f5, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {f5, 2'b00, rs2, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rs1, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {12'd0, rs1, 3'b010, rd, op};
    endfunction

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        fl;
        logic        es;
        logic [1:0]  ec;
        logic        eb;
    } vec_t;

    typedef struct {
        logic       es;
        logic [1:0] ec;
        logic       eb;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Compare DUT outputs mid-cycle against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (stall === e.es) passed++;
            else $display("FAIL %s stall: got %b expected %b", e.nm, stall, e.es);
            checks++;
            if (stall_cause === e.ec) passed++;
            else $display("FAIL %s stall_cause: got %b expected %b", e.nm, stall_cause, e.ec);
            checks++;
            if (fdiv_busy === e.eb) passed++;
            else $display("FAIL %s fdiv_busy: got %b expected %b", e.nm, fdiv_busy, e.eb);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] ins, input logic fl,
                       input logic es, input logic [1:0] ec, input logic eb, input string nm);
        @(posedge clk);
        #1;
        id_valid = v;
        id_instr = ins;
        flush    = fl;
        exp_q.push_back('{es, ec, eb, nm});
    endtask

    vec_t tbl[32];

    function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic fl,
                                input logic es, input logic [1:0] ec, input logic eb);
        vec_t r;
        r.v = v; r.ins = ins; r.fl = fl; r.es = es; r.ec = ec; r.eb = eb;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fdiv1, fadd2, fsqrt4, flw1, fadd5;
        fdiv1  = enc_r(5'b00011, 5'd3, 5'd2, 5'd1, OPFP);
        fadd2  = enc_r(5'b00000, 5'd3, 5'd1, 5'd2, OPFP);
        fsqrt4 = enc_r(5'b01011, 5'd0, 5'd5, 5'd4, OPFP);
        flw1   = enc_i(5'd0, 5'd1, FLW);
        fadd5  = enc_r(5'b00000, 5'd1, 5'd1, 5'd5, OPFP);

        tbl[0]  = mk(1, enc_i(5'd1, 5'd5, LOAD),          0, 0, 2'b00, 0);
        tbl[1]  = mk(1, enc_r(0, 5'd1, 5'd5, 5'd6, OP),   0, 1, 2'b01, 0);
        tbl[2]  = mk(1, enc_r(0, 5'd1, 5'd5, 5'd6, OP),   0, 0, 2'b00, 0);
        tbl[3]  = mk(0, 32'd0,                            0, 0, 2'b00, 0);
        tbl[4]  = mk(1, enc_i(5'd1, 5'd0, LOAD),          0, 0, 2'b00, 0);
        tbl[5]  = mk(1, enc_r(0, 5'd0, 5'd0, 5'd2, OP),   0, 0, 2'b00, 0);
        tbl[6]  = mk(1, enc_i(5'd0, 5'd0, FLW),           0, 0, 2'b00, 0);
        tbl[7]  = mk(1, enc_r(0, 5'd0, 5'd0, 5'd1, OPFP), 0, 1, 2'b01, 0);
        tbl[8]  = mk(1, enc_r(0, 5'd0, 5'd0, 5'd1, OPFP), 0, 0, 2'b00, 0);
        tbl[9]  = mk(0, 32'd0,                            0, 0, 2'b00, 0);
        tbl[10] = mk(0, 32'd0,                            0, 0, 2'b00, 0);
        tbl[11] = mk(1, enc_i(5'd1, 5'd7, LOAD),          1, 0, 2'b00, 0);
        tbl[12] = mk(1, enc_r(0, 5'd7, 5'd7, 5'd8, OP),   0, 0, 2'b00, 0);
        tbl[13] = mk(1, enc_i(5'd1, 5'd9, LOAD),          0, 0, 2'b00, 0);
        tbl[14] = mk(1, enc_r(0, 5'd0, 5'd0, 5'd9, OP),   0, 1, 2'b11, 0);
        tbl[15] = mk(1, enc_r(0, 5'd0, 5'd0, 5'd9, OP),   0, 0, 2'b00, 0);
        tbl[16] = mk(1, enc_i(5'd1, 5'd10, LOAD),         0, 0, 2'b00, 0);
        tbl[17] = mk(0, enc_r(0, 5'd0, 5'd10, 5'd11, OP), 0, 0, 2'b00, 0);
        tbl[18] = mk(1, enc_r(0, 5'd0, 5'd10, 5'd11, OP), 0, 0, 2'b00, 0);
        tbl[19] = mk(1, enc_i(5'd1, 5'd12, LOAD),         0, 0, 2'b00, 0);
        tbl[20] = mk(1, enc_r(0, 5'd0, 5'd12, 5'd13, OP), 1, 1, 2'b01, 0);
        tbl[21] = mk(0, 32'd0,                            0, 0, 2'b00, 0);
        tbl[22] = mk(1, enc_i(5'd1, 5'd14, LOAD),         0, 0, 2'b00, 0);
        tbl[23] = mk(1, enc_r(0, 5'd0, 5'd14, 5'd14, OP), 0, 1, 2'b01, 0);
        tbl[24] = mk(0, 32'd0,                            0, 0, 2'b00, 0);
        tbl[25] = mk(1, enc_i(5'd1, 5'd15, LOAD),         0, 0, 2'b00, 0);
        tbl[26] = mk(1, enc_r(0, 5'd15, 5'd0, 5'd0, STORE), 0, 1, 2'b01, 0);
        tbl[27] = mk(0, 32'd0,                            0, 0, 2'b00, 0);
        tbl[28] = mk(1, enc_r(5'b10100, 5'd0, 5'd0, 5'd16, OPFP), 0, 0, 2'b00, 0);
        tbl[29] = mk(1, enc_r(0, 5'd0, 5'd16, 5'd17, OP), 0, 1, 2'b01, 0);
        tbl[30] = mk(1, enc_r(0, 5'd0, 5'd16, 5'd17, OP), 0, 1, 2'b01, 0);
        tbl[31] = mk(1, enc_r(0, 5'd0, 5'd16, 5'd17, OP), 0, 0, 2'b00, 0);

        // Reset state: a dependent FP op in ID must not stall.
        cyc(1, fadd2, 0, 0, 2'b00, 0, "reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_valid = 1'b0;

        for (int i = 0; i < 32; i++) begin
            cyc(tbl[i].v, tbl[i].ins, tbl[i].fl, tbl[i].es, tbl[i].ec, tbl[i].eb,
                $sformatf("vec%0d", i));
        end

        // FDIV then dependent FADD: ten RAW cycles with the divider busy.
        cyc(1, fdiv1, 0, 0, 2'b00, 0, "fdiv_issue");
        for (int i = 0; i < 10; i++) cyc(1, fadd2, 0, 1, 2'b01, 1, $sformatf("fdiv_raw%0d", i));
        cyc(1, fadd2, 0, 0, 2'b00, 0, "fadd_issue");
        for (int i = 0; i < 3; i++) cyc(0, 32'd0, 0, 0, 2'b00, 0, "idle_a");

        // FDIV then independent FSQRT: structural stall until the divider frees.
        cyc(1, fdiv1, 0, 0, 2'b00, 0, "fdiv2_issue");
        for (int i = 0; i < 10; i++) cyc(1, fsqrt4, 0, 1, 2'b10, 1, $sformatf("struct%0d", i));
        cyc(1, fsqrt4, 0, 0, 2'b00, 0, "fsqrt_issue");
        for (int i = 0; i < 10; i++) cyc(0, 32'd0, 0, 0, 2'b00, 1, $sformatf("sqrt_busy%0d", i));
        cyc(0, 32'd0, 0, 0, 2'b00, 0, "sqrt_done");

        // FDIV then FLW to the same register: WAW until fcnt[1] reaches 1, then reload to 1.
        cyc(1, fdiv1, 0, 0, 2'b00, 0, "fdiv3_issue");
        for (int i = 0; i < 9; i++) cyc(1, flw1, 0, 1, 2'b11, 1, $sformatf("waw%0d", i));
        cyc(1, flw1, 0, 0, 2'b00, 1, "flw_issue");
        cyc(1, fadd5, 0, 1, 2'b01, 0, "flw_reload");
        cyc(1, fadd5, 0, 0, 2'b00, 0, "fadd5_issue");
        for (int i = 0; i < 3; i++) cyc(0, 32'd0, 0, 0, 2'b00, 0, "idle_b");

        // Reset in the middle of a divide clears everything immediately.
        cyc(1, fdiv1, 0, 0, 2'b00, 0, "fdiv4_issue");
        for (int i = 0; i < 4; i++) cyc(1, fadd2, 0, 1, 2'b01, 1, $sformatf("pre_rst%0d", i));
        @(posedge clk);
        #1;
        rst = 1'b1;
        id_valid = 1'b1;
        id_instr = fadd2;
        flush = 1'b0;
        exp_q.push_back('{1'b0, 2'b00, 1'b0, "mid_rst"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back('{1'b0, 2'b00, 1'b0, "post_rst"});
        cyc(0, 32'd0, 0, 0, 2'b00, 0, "post_rst_idle");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
